// File: rtl/reset_sequencer_if.sv
// Request inputs and staggered reset outputs of the reset sequencer.
// The master side is the sequencer; the slave side is the requester/consumer.
interface reset_sequencer_if #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned NUM_SRC = 2
);
   logic [NUM_SRC-1:0] rst_req;
   logic [NUM_CH-1:0]  rst_n_out;
   logic               seq_busy;
   logic               all_released;
   logic               timeout_flag;
   logic [7:0]         reset_count;

   modport master (
      input  rst_req,
      output rst_n_out,
      output seq_busy,
      output all_released,
      output timeout_flag,
      output reset_count
   );

   modport slave (
      output rst_req,
      input  rst_n_out,
      input  seq_busy,
      input  all_released,
      input  timeout_flag,
      input  reset_count
   );
endinterface

// File: rtl/reset_sequencer.sv
// Merges async soft-reset requests with the external reset, stretches the reset and
// releases the downstream channels one by one; a run-time watchdog follows the release.
module reset_sequencer #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned NUM_SRC     = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRETCH     = 16,
   parameter int unsigned STAGGER     = 4,
   parameter int unsigned TIMEOUT     = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   reset_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0] StretchLast = CNT_W'(STRETCH - 1);
   localparam logic [CNT_W-1:0] StaggerLast = CNT_W'(STAGGER - 1);
   localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StAssert, StRelease, StRun} state_e;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic               req_raw;
   logic               req_q;
   logic [7:0]         count_q;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   run_q;
   logic [CNT_W-1:0]   step_last;
   logic [NUM_CH-1:0]  chan_q;
   logic [NUM_CH-1:0]  chan_next;
   logic               busy_q;
   logic               released_q;
   logic               timeout_q;

   assign req_raw   = |sync_q[SYNC_STAGES-1];
   // Thermometer shift keeps channel release strictly in index order.
   assign chan_next = (chan_q << 1) | NUM_CH'(1);
   assign step_last = (state_q == StAssert) ? StretchLast : StaggerLast;

   // Request synchronisers; req_q adds the extra stage the FSM decision is made from.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         req_q   <= 1'b0;
         count_q <= 8'd0;
      end else begin
         sync_q[0] <= bus.rst_req;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         req_q <= req_raw;
         if (req_raw && !req_q && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StAssert;
         cnt_q      <= '0;
         run_q      <= '0;
         chan_q     <= '0;
         busy_q     <= 1'b1;
         released_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (req_q) begin
         // Any request restarts the whole sequence from any state.
         state_q    <= StAssert;
         cnt_q      <= '0;
         run_q      <= '0;
         chan_q     <= '0;
         busy_q     <= 1'b1;
         released_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StAssert, StRelease: begin
               if (cnt_q == step_last) begin
                  cnt_q  <= '0;
                  chan_q <= chan_next;
                  if (&chan_next) begin
                     state_q    <= StRun;
                     run_q      <= '0;
                     busy_q     <= 1'b0;
                     released_q <= 1'b1;
                  end else begin
                     state_q <= StRelease;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StRun: begin
               if (TIMEOUT != 0) begin
                  if (run_q != TimeoutVal) run_q <= run_q + CNT_W'(1);
                  if (run_q == TimeoutLast) timeout_q <= 1'b1;
               end else if (run_q != '1) begin
                  run_q <= run_q + CNT_W'(1);
               end
            end
            default: state_q <= StAssert;
         endcase
      end
   end

   assign bus.rst_n_out    = chan_q;
   assign bus.seq_busy     = busy_q;
   assign bus.all_released = released_q;
   assign bus.timeout_flag = timeout_q;
   assign bus.reset_count  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboarded bench: two sequencers (watchdog off / TIMEOUT=100) share stimulus and are
// checked every cycle against an edge-count model of the release schedule.
module tb_reset_sequencer;

   localparam int NumCh    = 4;
   localparam int NumSrc   = 2;
   localparam int Stretch  = 16;
   localparam int Stagger  = 4;
   localparam int Timeout1 = 100;
   localparam int Full     = Stretch + (NumCh - 1) * Stagger;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   reset_sequencer_if #(.NUM_CH(NumCh), .NUM_SRC(NumSrc)) bus0 ();
   reset_sequencer_if #(.NUM_CH(NumCh), .NUM_SRC(NumSrc)) bus1 ();

   reset_sequencer #(
      .NUM_CH(NumCh), .NUM_SRC(NumSrc), .SYNC_STAGES(2), .STRETCH(Stretch),
      .STAGGER(Stagger), .TIMEOUT(0), .CNT_W(32)
   ) u_dut0 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus0)
   );

   reset_sequencer #(
      .NUM_CH(NumCh), .NUM_SRC(NumSrc), .SYNC_STAGES(2), .STRETCH(Stretch),
      .STAGGER(Stagger), .TIMEOUT(Timeout1), .CNT_W(32)
   ) u_dut1 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus1)
   );

   typedef struct packed {
      logic [3:0] ch;
      logic       busy;
      logic       all;
      logic       flag0;
      logic       flag1;
      logic [7:0] rc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Model: edges since reset release, edge of the last request the FSM acted on,
   // soft-reset event count, and the OR of rst_req sampled at each edge.
   int   n_edge  = 0;
   int   last_ev = 0;
   int   rc      = 0;
   bit   samp[$];

   function automatic bit s_at(int m);
      if (m < 1 || m > samp.size()) return 1'b0;
      return samp[m-1];
   endfunction

   function automatic exp_t model_out(int k);
      exp_t e;
      for (int i = 0; i < NumCh; i++) e.ch[i] = (k >= Stretch + i * Stagger);
      e.all   = (k >= Full);
      e.busy  = !e.all;
      e.flag0 = 1'b0;
      e.flag1 = (k >= Full + Timeout1);
      e.rc    = rc[7:0];
      return e;
   endfunction

   function automatic logic [14:0] act0();
      return {bus0.rst_n_out, bus0.seq_busy, bus0.all_released, bus0.timeout_flag,
              bus0.reset_count};
   endfunction

   function automatic logic [14:0] act1();
      return {bus1.rst_n_out, bus1.seq_busy, bus1.all_released, bus1.timeout_flag,
              bus1.reset_count};
   endfunction

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got ch=%b busy=%b all=%b flag=%b cnt=%0d, expected ch=%b busy=%b all=%b flag=%b cnt=%0d",
                  name, $time, act[14:11], act[10], act[9], act[8], act[7:0],
                  exp[14:11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   // Drive one clock's worth of stimulus and push what the DUTs must show after that edge.
   task automatic step(input logic [1:0] req, input logic rst_val);
      @(negedge clk);
      rst_n        = rst_val;
      bus0.rst_req = req;
      bus1.rst_req = req;
      if (!rst_val) begin
         n_edge  = 0;
         last_ev = 0;
         rc      = 0;
         samp.delete();
         exp_q.push_back(model_out(0));
      end else begin
         n_edge++;
         samp.push_back(|req);
         if (s_at(n_edge - 3)) last_ev = n_edge;
         if (s_at(n_edge - 2) && !s_at(n_edge - 3) && rc < 255) rc++;
         exp_q.push_back(model_out(n_edge - last_ev));
      end
   endtask

   task automatic request(input logic [1:0] req);
      step(req, 1'b1);
      repeat (3) step(2'b00, 1'b1);
   endtask

   task automatic quiet_until(input int target);
      int guard = 0;
      while ((n_edge - last_ev) != target && guard < 200) begin
         step(2'b00, 1'b1);
         guard++;
      end
      if ((n_edge - last_ev) != target) begin
         n_vec++;
         n_err++;
         $display("FAIL quiet_until: got k=%0d, expected k=%0d", n_edge - last_ev, target);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("dut0", act0(), {e.ch, e.busy, e.all, e.flag0, e.rc});
         check("dut1", act1(), {e.ch, e.busy, e.all, e.flag1, e.rc});
      end
   end

   initial begin
      bus0.rst_req = '0;
      bus1.rst_req = '0;
      repeat (3) step(2'b00, 1'b0);

      // Power-on release, then a one-cycle request while running.
      repeat (40) step(2'b00, 1'b1);
      step(2'b10, 1'b1);
      repeat (40) step(2'b00, 1'b1);

      // Long held request.
      repeat (50) step(2'b01, 1'b1);
      repeat (40) step(2'b00, 1'b1);

      // Request landing between the ch1 and ch2 releases.
      request(2'b01);
      quiet_until(19);
      step(2'b01, 1'b1);
      repeat (40) step(2'b00, 1'b1);

      // Long run: watchdog sets on dut1 only, then a soft request clears it.
      repeat (10150) step(2'b00, 1'b1);
      request(2'b10);
      repeat (40) step(2'b00, 1'b1);

      // Random request traffic, including simultaneous bits.
      for (int i = 0; i < 2000; i++) begin
         step({($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)}, 1'b1);
      end
      repeat (40) step(2'b00, 1'b1);

      // Async reset between edges while mid-release.
      request(2'b01);
      quiet_until(20);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_dut0", act0(), {4'b0000, 1'b1, 1'b0, 1'b0, 8'd0});
      check("async_rst_dut1", act1(), {4'b0000, 1'b1, 1'b0, 1'b0, 8'd0});
      repeat (3) step(2'b00, 1'b0);
      repeat (40) step(2'b00, 1'b1);

      // Event counter saturation.
      repeat (300) begin
         step(2'b10, 1'b1);
         step(2'b00, 1'b1);
      end
      step(2'b11, 1'b1);
      repeat (10) step(2'b00, 1'b1);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
